// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter: circular buffer plus a small
// IDLE/START/WAIT sequencer that pops one character per frame.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     flush_i,
    input  logic                     tx_done_i,
    output logic                     start_tx_o,
    output logic [31:0]              tx_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]       count_reg, count_next;
    logic [DATA_W-1:0]   tx_data_reg;
    logic                start_reg;
    logic                overflow_reg;
    logic                push, pop, drop;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign full_o     = (count_reg == CW'(DEPTH));
    assign empty_o    = (count_reg == '0);
    assign count_o    = count_reg;
    assign start_tx_o = start_reg;
    assign overflow_o = overflow_reg;
    assign busy_o     = (state_reg != IDLE);
    assign tx_data_o  = 32'(tx_data_reg);

    // Flush wins over everything; a pop frees the slot a full-FIFO write needs.
    assign pop  = (state_reg == IDLE) && !empty_o && !flush_i;
    assign push = wr_en_i && !flush_i && (!full_o || pop);
    assign drop = wr_en_i && !flush_i && full_o && !pop;

    always_comb begin
        count_next = count_reg;
        if (flush_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pop) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (tx_done_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            tx_data_reg  <= '0;
            start_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            start_reg    <= (state_next == START);
            overflow_reg <= drop;
            if (flush_i) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (pop) tx_data_reg <= mem[rd_ptr_reg];
        end
    end

    // Storage is kept out of the reset domain so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wr_data_i;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, FIFO entry count; power of two, minimum 2.
REQ-002 The block SHALL have parameter DATA_W, default 8, stored character width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 The block SHALL have port wr_en_i, input, 1, one-cycle write strobe from the register block.
REQ-006 The block SHALL have port wr_data_i, input, DATA_W, the character to enqueue.
REQ-007 The block SHALL have port flush_i, input, 1, synchronous FIFO clear.
REQ-008 The block SHALL have port tx_done_i, input, 1, frame-complete pulse from the UART transmitter.
REQ-009 The block SHALL have port start_tx_o, output, 1, start pulse to the UART transmitter.
REQ-010 The block SHALL have port tx_data_o, output, 32, character for the transmitter, zero-extended from DATA_W.
REQ-011 The block SHALL have port full_o, output, 1, high when count_o equals DEPTH.
REQ-012 The block SHALL have port empty_o, output, 1, high when count_o equals 0.
REQ-013 The block SHALL have port count_o, output, $clog2(DEPTH)+1, number of stored entries.
REQ-014 The block SHALL have port overflow_o, output, 1, one-cycle pulse for a dropped write.
REQ-015 The block SHALL have port busy_o, output, 1, high while the FSM is not in IDLE.

Function
REQ-016 Storage SHALL be a circular buffer: write pointer, read pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-017 A write with count_o < DEPTH SHALL store wr_data_i at the write pointer, advance the pointer and increment count_o, all on the same edge.
REQ-018 Write when full, no same-cycle pop:
- data dropped;
- pointers and count unchanged;
- overflow_o high for exactly the next cycle.
REQ-019 Write and pop on the same edge SHALL both succeed, including when full or empty-before-write is not involved; count_o is unchanged.
REQ-020 FSM states SHALL be IDLE, START and WAIT.
REQ-021 IDLE: if empty_o=0, pop the head into the tx_data_o register, advance the read pointer, decrement count and go to START; otherwise stay in IDLE.
REQ-022 START: start_tx_o=1 for this single cycle; the next state is unconditionally WAIT.
REQ-023 WAIT: stay until tx_done_i=1, then go to IDLE; a back-to-back pop is possible on the next IDLE edge.
REQ-024 tx_done_i outside WAIT SHALL be ignored.
REQ-025 start_tx_o SHALL be registered and high only in START.
REQ-026 tx_data_o SHALL change only on a pop and SHALL be stable from START until the next pop.
REQ-027 Latency: a write sampled at edge k into an empty FIFO in IDLE gives:
- count_o=1 after edge k;
- pop at edge k+1;
- start_tx_o high between edges k+1 and k+2.
REQ-028 flush_i=1 SHALL zero the pointers and count_o on that edge, with priority over any same-cycle write and pop.
- The write is dropped with no overflow_o.
- In IDLE, no pop occurs.
REQ-029 A flush in START or WAIT SHALL NOT abort the FSM.
- The in-flight frame completes.
- tx_data_o is held.
REQ-030 Flags SHALL be registered or derived combinationally from the registered count only, with no combinational path from wr_en_i.

Reset
REQ-031 rst=1 SHALL immediately force, regardless of clk:
- FSM to IDLE;
- pointers and count_o to 0;
- start_tx_o=0, tx_data_o=0, overflow_o=0, busy_o=0;
- full_o=0, empty_o=1.
REQ-032 Storage array contents SHALL need no reset.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; a tx_done_i arriving after deassertion SHALL be ignored.

Verification
REQ-034 Scenario: single write 0xA5 at edge k in IDLE -> start_tx_o one cycle at k+1..k+2, tx_data_o=0x000000A5, busy_o=1 until tx_done_i, count_o back to 0.
REQ-035 Scenario: 17 writes with DEPTH=16 while WAIT holds the first frame -> first pops; 16 stored, full_o=1; 17th gives no overflow. An 18th write gives an overflow_o pulse and count_o stays 16.
REQ-036 Scenario: writes 0x01..0x05, tx_done_i 3 cycles after each start -> exactly five start_tx_o pulses with tx_data_o 0x01..0x05 in order.
REQ-037 Scenario: FIFO full, wr_en_i and IDLE pop on the same edge -> count_o stays 16, no overflow_o, new data emerges last.
REQ-038 Scenario: flush_i with a write on the same edge during WAIT with 4 entries -> count_o=0, no overflow_o, current frame completes, no further start_tx_o.
REQ-039 Scenario: rst pulsed asynchronously between edges in WAIT with 3 entries -> outputs take reset values without a clock, then a late tx_done_i causes no start_tx_o.
